// File: rtl/issueq_free_list_pkg.sv
// Shared types and sizing for the issue-queue free list.
package issueq_free_list_pkg;

  localparam int SIZE_ISSUEQ      = 32;
  localparam int SIZE_ISSUEQ_LOG  = 5;
  localparam int DISPATCH_WIDTH   = 4;
  localparam int IQ_FREEING_WIDTH = 4;

  typedef logic [SIZE_ISSUEQ_LOG-1:0] iq_id_t;
  typedef logic [SIZE_ISSUEQ_LOG:0]   iq_cnt_t;

  // One freed-entry lane from the IQ freeing stage.
  typedef struct packed {
    logic   valid;
    iq_id_t id;
  } iq_entry_pkt;

  localparam iq_cnt_t FULL_CNT = iq_cnt_t'(SIZE_ISSUEQ);
  localparam iq_cnt_t DW_CNT   = iq_cnt_t'(DISPATCH_WIDTH);
  localparam iq_id_t  DW_STEP  = iq_id_t'(DISPATCH_WIDTH);

endpackage

// File: rtl/issueq_free_list_ram.sv
// Free-list storage: DISPATCH_WIDTH async read ports, IQ_FREEING_WIDTH sync
// write ports. Reset and init both reload the identity map ram[k] = k.
module issueq_free_list_ram
  import issueq_free_list_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              init_i,
  input  iq_id_t [DISPATCH_WIDTH-1:0]       raddr,
  output iq_id_t [DISPATCH_WIDTH-1:0]       rdata,
  input  logic   [IQ_FREEING_WIDTH-1:0]     we,
  input  iq_id_t [IQ_FREEING_WIDTH-1:0]     waddr,
  input  iq_id_t [IQ_FREEING_WIDTH-1:0]     wdata
);

  iq_id_t mem [SIZE_ISSUEQ];

  // Storage update: identity load on reset/init, otherwise all write lanes at once.
  // Write addresses never collide because the top compacts lanes onto distinct slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SIZE_ISSUEQ; k++) mem[k] <= iq_id_t'(k);
    end else if (init_i) begin
      for (int k = 0; k < SIZE_ISSUEQ; k++) mem[k] <= iq_id_t'(k);
    end else begin
      for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
        if (we[j]) mem[waddr[j]] <= wdata[j];
      end
    end
  end

  // Combinational read of the dispatch window.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) rdata[i] = mem[raddr[i]];
  end

endmodule

// File: rtl/issueq_free_list.sv
// Circular free list of issue-queue entry IDs. Freed IDs are compacted onto
// the tail; dispatch takes DISPATCH_WIDTH IDs from the head. Full vs empty is
// tracked only by the occupancy counter, never by pointer comparison.
module issueq_free_list
  import issueq_free_list_pkg::*;
(
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            flush_i,
  input  logic                                            iqAlloc_i,
  input  iq_entry_pkt [IQ_FREEING_WIDTH-1:0]              freedEntry_i,
  output logic [DISPATCH_WIDTH-1:0][SIZE_ISSUEQ_LOG-1:0]  freeEntry_o,
  output logic [SIZE_ISSUEQ_LOG:0]                        freeCnt_o,
  output logic                                            iqFreeStall_o
);

  iq_id_t  head;
  iq_id_t  tail;
  iq_cnt_t count;
  iq_cnt_t count_next;

  logic    stall;
  logic    pop;
  iq_id_t  push_cnt;
  iq_id_t  [IQ_FREEING_WIDTH-1:0] lane_off;

  iq_id_t  [DISPATCH_WIDTH-1:0]   raddr;
  iq_id_t  [DISPATCH_WIDTH-1:0]   rdata;
  logic    [IQ_FREEING_WIDTH-1:0] we;
  iq_id_t  [IQ_FREEING_WIDTH-1:0] waddr;
  iq_id_t  [IQ_FREEING_WIDTH-1:0] wdata;

  // Stall looks at the registered count only; same-cycle pushes never help.
  assign stall = (count < DW_CNT);
  assign pop   = iqAlloc_i & ~stall & ~flush_i;

  // Prefix sum over valid lanes: each valid lane gets the next free tail slot.
  always_comb begin
    push_cnt = '0;
    lane_off = '0;
    for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
      lane_off[j] = push_cnt;
      if (freedEntry_i[j].valid) push_cnt = push_cnt + iq_id_t'(1);
    end
  end

  // Write lanes and read window addresses; both wrap naturally at SIZE.
  always_comb begin
    we    = '0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
      we[j]    = freedEntry_i[j].valid & ~flush_i;
      waddr[j] = tail + lane_off[j];
      wdata[j] = freedEntry_i[j].id;
    end
    for (int i = 0; i < DISPATCH_WIDTH; i++) raddr[i] = head + iq_id_t'(i);
  end

  assign count_next = count + {1'b0, push_cnt} - (pop ? DW_CNT : '0);

  // Pointer and occupancy registers; flush reloads the full identity state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= FULL_CNT;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= FULL_CNT;
    end else begin
      if (pop) head <= head + DW_STEP;
      tail  <= tail + push_cnt;
      count <= count_next;
    end
  end

  issueq_free_list_ram u_ram (
    .clk    (clk),
    .reset  (reset),
    .init_i (flush_i),
    .raddr  (raddr),
    .rdata  (rdata),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata)
  );

  assign freeEntry_o   = rdata;
  assign freeCnt_o     = count;
  assign iqFreeStall_o = stall;

`ifndef SYNTHESIS
  logic [SIZE_ISSUEQ-1:0] shadow;
  logic [SIZE_ISSUEQ-1:0] shadow_next;
  logic                   dup_push;

  // Shadow membership: popped IDs leave, pushed IDs must not already be present.
  always_comb begin
    shadow_next = shadow;
    dup_push    = 1'b0;
    if (pop) begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) shadow_next[freeEntry_o[i]] = 1'b0;
    end
    for (int j = 0; j < IQ_FREEING_WIDTH; j++) begin
      if (freedEntry_i[j].valid) begin
        if (shadow_next[freedEntry_i[j].id]) dup_push = 1'b1;
        shadow_next[freedEntry_i[j].id] = 1'b1;
      end
    end
  end

  // Shadow register tracks the list contents as a bit-vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        shadow <= '1;
    else if (flush_i) shadow <= '1;
    else              shadow <= shadow_next;
  end

  ap_alloc_while_stalled: assert property (@(posedge clk) disable iff (reset)
    !(iqAlloc_i && stall && !flush_i))
    else $error("protocol error: iqAlloc_i asserted while stalled");

  ap_count_overflow: assert property (@(posedge clk) disable iff (reset)
    !flush_i |-> (count_next <= FULL_CNT))
    else $error("free list occupancy exceeds capacity");

  ap_no_duplicate: assert property (@(posedge clk) disable iff (reset)
    !flush_i |-> !dup_push)
    else $error("duplicate id pushed into free list");

  for (genvar g = 0; g < IQ_FREEING_WIDTH; g++) begin : g_id_range
    ap_id_range: assert property (@(posedge clk) disable iff (reset)
      freedEntry_i[g].valid |-> ({1'b0, freedEntry_i[g].id} < FULL_CNT))
      else $error("pushed id out of range");
  end
`endif

endmodule

// File: tb/tb_issueq_free_list.sv
// Directed bench for the issue-queue free list.
module tb_issueq_free_list;
  import issueq_free_list_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic alloc;
  iq_entry_pkt [IQ_FREEING_WIDTH-1:0] freed;
  logic [DISPATCH_WIDTH-1:0][SIZE_ISSUEQ_LOG-1:0] free_entry;
  logic [SIZE_ISSUEQ_LOG:0] free_cnt;
  logic stall;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  issueq_free_list dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush),
    .iqAlloc_i     (alloc),
    .freedEntry_i  (freed),
    .freeEntry_o   (free_entry),
    .freeCnt_o     (free_cnt),
    .iqFreeStall_o (stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ids(input int a, input int b, input int c, input int d);
    return {12'd0, d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  task automatic check_state(input string tag, input logic [31:0] fe, input int cnt, input logic st);
    logic [31:0] cnt_w;
    cnt_w = cnt;
    check({tag, "_ids"},   32'(free_entry), fe);
    check({tag, "_cnt"},   32'(free_cnt),   cnt_w);
    check({tag, "_stall"}, 32'(stall),      32'(st));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [3:0] v, input int a, input int b, input int c, input int d);
    freed[0].valid = v[0]; freed[0].id = a[4:0];
    freed[1].valid = v[1]; freed[1].id = b[4:0];
    freed[2].valid = v[2]; freed[2].id = c[4:0];
    freed[3].valid = v[3]; freed[3].id = d[4:0];
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    alloc = 1'b0;
    freed = '0;
    tick;
    tick;
    reset = 1'b0;

    // Reset state, then steady with no traffic
    check_state("reset", ids(0, 1, 2, 3), 32, 1'b0);
    repeat (3) tick;
    check_state("idle", ids(0, 1, 2, 3), 32, 1'b0);

    // Drain all 32 IDs in order
    alloc = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_ids", 32'(free_entry), ids(4*k, 4*k+1, 4*k+2, 4*k+3));
      check("drain_cnt", 32'(free_cnt), 32'(32 - 4*k));
      tick;
    end
    alloc = 1'b0;
    check_state("drained", ids(0, 1, 2, 3), 0, 1'b1);

    // Sparse push from empty: lanes 1,3 -> slots 0,1
    set_push(4'b1010, 0, 9, 0, 5);
    tick;
    freed = '0;
    check_state("push2", ids(9, 5, 2, 3), 2, 1'b1);
    set_push(4'b0101, 12, 0, 20, 0);
    tick;
    freed = '0;
    check_state("push4", ids(9, 5, 12, 20), 4, 1'b0);

    // Reach count 6, then simultaneous pop and 4-lane push
    set_push(4'b1010, 0, 1, 0, 7);
    tick;
    freed = '0;
    check_state("cnt6", ids(9, 5, 12, 20), 6, 1'b0);
    alloc = 1'b1;
    set_push(4'b1111, 0, 2, 3, 4);
    check("popped_old_head", 32'(free_entry), ids(9, 5, 12, 20));
    tick;
    alloc = 1'b0;
    freed = '0;
    check_state("pushpop", ids(1, 7, 0, 2), 6, 1'b0);

    // Fill tail up to slot 30, then push across the wrap
    for (int k = 0; k < 5; k++) begin
      set_push(4'b1111, 8+4*k, 9+4*k, 10+4*k, 11+4*k);
      tick;
    end
    freed = '0;
    check("fill_cnt", 32'(free_cnt), 32'd26);
    set_push(4'b1111, 28, 29, 30, 31);
    tick;
    freed = '0;
    check_state("wrap_push", ids(1, 7, 0, 2), 30, 1'b0);

    // Pop from head 4 through head 28 and wrap to head 0
    alloc = 1'b1;
    check("pop_h4", 32'(free_entry), ids(1, 7, 0, 2));
    tick;
    check("pop_h8", 32'(free_entry), ids(3, 4, 8, 9));
    tick;
    for (int h = 12; h <= 28; h += 4) begin
      check("pop_hn", 32'(free_entry), ids(h-2, h-1, h, h+1));
      tick;
    end
    alloc = 1'b0;
    check_state("wrap_pop", ids(30, 31, 12, 20), 2, 1'b1);

    // Refill, then flush together with alloc and push
    set_push(4'b1111, 5, 6, 9, 12);
    tick;
    freed = '0;
    check_state("refill", ids(30, 31, 5, 6), 6, 1'b0);
    flush = 1'b1;
    alloc = 1'b1;
    set_push(4'b1111, 0, 1, 2, 3);
    tick;
    flush = 1'b0;
    alloc = 1'b0;
    freed = '0;
    check_state("flush", ids(0, 1, 2, 3), 32, 1'b0);
    alloc = 1'b1;
    tick;
    alloc = 1'b0;
    check_state("post_flush_pop", ids(4, 5, 6, 7), 28, 1'b0);

    // Async reset between edges, held across an edge with alloc high
    #3;
    reset = 1'b1;
    #1;
    check_state("async_reset", ids(0, 1, 2, 3), 32, 1'b0);
    alloc = 1'b1;
    tick;
    check_state("reset_hold", ids(0, 1, 2, 3), 32, 1'b0);
    alloc = 1'b0;
    reset = 1'b0;
    tick;
    check_state("reset_release", ids(0, 1, 2, 3), 32, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
